// File: rtl/data_memory_be.sv
// Byte-enabled data memory with sign/zero-extending loads.
// Zero-fills itself after reset, then accepts one access per cycle.
module data_memory_be #(
  parameter int MEMORY_DEPTH = 64,
  parameter int ADDR_WIDTH   = 32,
  parameter int READ_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  Req_i,
  input  logic                  Write_i,
  input  logic [1:0]            Size_i,
  input  logic                  Unsigned_i,
  input  logic [ADDR_WIDTH-1:0] Address_i,
  input  logic [31:0]           Write_Data_i,
  output logic                  Ready_o,
  output logic                  Read_Valid_o,
  output logic [31:0]           Read_Data_o,
  output logic                  Error_o
);

  localparam int IDX_W = $clog2(MEMORY_DEPTH);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(MEMORY_DEPTH - 1);

  typedef enum logic {
    INIT,
    IDLE
  } state_t;

  typedef struct packed {
    logic        valid;
    logic        load;
    logic        err;
    logic [1:0]  size;
    logic [1:0]  lane;
    logic        uns;
    logic [31:0] word;
  } stage_t;

  logic [31:0] mem [MEMORY_DEPTH];

  state_t           state_q, state_d;
  logic [IDX_W-1:0] cnt_q, cnt_d;

  logic             accept;
  logic             is_byte, is_half;
  logic             misalign, oor, bad;
  logic [IDX_W-1:0] idx;
  logic [1:0]       lane;
  logic [3:0]       be;
  logic [31:0]      wd_rep;
  logic [31:0]      rd_word;

  stage_t      s_in;
  stage_t      pipe_q [READ_LATENCY];
  stage_t      last;
  logic [31:0] sh;
  logic [31:0] result;
  logic [31:0] hold_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == INIT) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == LAST) begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    end
  end

  assign Ready_o = (state_q == IDLE) && !reset;
  assign accept  = Req_i && Ready_o;

  assign is_byte  = (Size_i == 2'b00);
  assign is_half  = (Size_i == 2'b01);
  assign lane     = Address_i[1:0];
  assign idx      = Address_i[IDX_W+1:2];
  assign misalign = (is_half && lane[0]) ||
                    (Size_i[1] && (lane != 2'b00));
  assign oor      = 64'(Address_i) >= 64'(4 * MEMORY_DEPTH);
  assign bad      = misalign || oor;
  assign rd_word  = mem[idx];

  always_comb begin
    be     = 4'hF;
    wd_rep = Write_Data_i;
    unique case (1'b1)
      is_byte: begin
        be     = 4'b0001 << lane;
        wd_rep = {4{Write_Data_i[7:0]}};
      end
      is_half: begin
        be     = lane[1] ? 4'b1100 : 4'b0011;
        wd_rep = {2{Write_Data_i[15:0]}};
      end
      default: begin
        be     = 4'hF;
        wd_rep = Write_Data_i;
      end
    endcase
  end

  // A load issued right after a store reads the already-updated word.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state_q == INIT) begin
        mem[cnt_q] <= '0;
      end else if (accept && Write_i && !bad) begin
        for (int i = 0; i < 4; i++) begin
          if (be[i]) mem[idx][8*i +: 8] <= wd_rep[8*i +: 8];
        end
      end
    end
  end

  always_comb begin
    s_in       = '0;
    s_in.valid = accept;
    s_in.load  = !Write_i;
    s_in.err   = bad;
    s_in.size  = Size_i;
    s_in.lane  = lane;
    s_in.uns   = Unsigned_i;
    s_in.word  = rd_word;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < READ_LATENCY; i++) pipe_q[i] <= '0;
    end else begin
      pipe_q[0] <= s_in;
      for (int i = 1; i < READ_LATENCY; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign last = pipe_q[READ_LATENCY-1];
  assign sh   = last.word >> {last.lane, 3'b000};

  always_comb begin
    result = '0;
    if (!last.err) begin
      unique case (1'b1)
        (last.size == 2'b00):
          result = {{24{!last.uns && sh[7]}}, sh[7:0]};
        (last.size == 2'b01):
          result = {{16{!last.uns && sh[15]}}, sh[15:0]};
        default:
          result = last.word;
      endcase
    end
  end

  assign Read_Valid_o = last.valid && last.load;
  assign Error_o      = last.valid && last.err;
  assign Read_Data_o  = Read_Valid_o ? result : hold_q;

  always_ff @(posedge clk) begin
    if (reset) hold_q <= '0;
    else if (Read_Valid_o) hold_q <= result;
  end

endmodule

// File: tb/tb_data_memory_be.sv
// Bench for data_memory_be: latency-1 and latency-3 copies
// driven in lockstep, checked against a cycle-stamped queue.
module tb_data_memory_be;

  localparam int DEPTH = 12;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req = 1'b0;
  logic        wr = 1'b0;
  logic        uns = 1'b0;
  logic [1:0]  size = 2'b00;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;

  logic        rdy1, rv1, err1;
  logic        rdy3, rv3, err3;
  logic [31:0] rd1, rd3;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  bit mon_en = 1'b0;

  logic [31:0] last1 = '0;
  logic [31:0] last3 = '0;

  typedef struct {
    int          acc;
    bit          ld;
    bit          err;
    logic [31:0] data;
  } ent_t;

  ent_t q1[$];
  ent_t q3[$];
  ent_t e1, e3;
  bit   hit1, hit3;

  data_memory_be #(
    .MEMORY_DEPTH(DEPTH), .ADDR_WIDTH(32), .READ_LATENCY(1)
  ) dut1 (
    .clk(clk), .reset(reset), .Req_i(req), .Write_i(wr),
    .Size_i(size), .Unsigned_i(uns), .Address_i(addr),
    .Write_Data_i(wdata), .Ready_o(rdy1), .Read_Valid_o(rv1),
    .Read_Data_o(rd1), .Error_o(err1)
  );

  data_memory_be #(
    .MEMORY_DEPTH(DEPTH), .ADDR_WIDTH(32), .READ_LATENCY(3)
  ) dut3 (
    .clk(clk), .reset(reset), .Req_i(req), .Write_i(wr),
    .Size_i(size), .Unsigned_i(uns), .Address_i(addr),
    .Write_Data_i(wdata), .Ready_o(rdy3), .Read_Valid_o(rv3),
    .Read_Data_o(rd3), .Error_o(err3)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial forever begin
    @(negedge clk);
    if (mon_en) begin
      hit1 = 1'b0;
      if (q1.size() > 0) hit1 = (q1[0].acc + 1 == cyc);
      if (hit1) e1 = q1.pop_front();
      else e1 = '{0, 1'b0, 1'b0, 32'h0};
      checks++;
      assert ({rv1, err1} === {hit1 && e1.ld, hit1 && e1.err})
      else begin
        failures++;
        $error("FAIL lat1_pulse cyc=%0d got rv,err=%b%b exp=%b%b",
               cyc, rv1, err1, hit1 && e1.ld, hit1 && e1.err);
      end
      if (hit1 && e1.ld) begin
        checks++;
        assert (rd1 === e1.data)
        else begin
          failures++;
          $error("FAIL lat1_data cyc=%0d got=%h exp=%h",
                 cyc, rd1, e1.data);
        end
        last1 = e1.data;
      end

      hit3 = 1'b0;
      if (q3.size() > 0) hit3 = (q3[0].acc + 3 == cyc);
      if (hit3) e3 = q3.pop_front();
      else e3 = '{0, 1'b0, 1'b0, 32'h0};
      checks++;
      assert ({rv3, err3} === {hit3 && e3.ld, hit3 && e3.err})
      else begin
        failures++;
        $error("FAIL lat3_pulse cyc=%0d got rv,err=%b%b exp=%b%b",
               cyc, rv3, err3, hit3 && e3.ld, hit3 && e3.err);
      end
      if (hit3 && e3.ld) begin
        checks++;
        assert (rd3 === e3.data)
        else begin
          failures++;
          $error("FAIL lat3_data cyc=%0d got=%h exp=%h",
                 cyc, rd3, e3.data);
        end
        last3 = e3.data;
      end
    end
  end

  task automatic acc(input bit w, input logic [1:0] sz,
                     input bit u, input logic [31:0] a,
                     input logic [31:0] d, input logic [31:0] exp,
                     input bit experr);
    ent_t e;
    @(negedge clk); #1;
    req = 1'b1; wr = w; size = sz; uns = u; addr = a; wdata = d;
    checks++;
    assert (rdy1 === 1'b1 && rdy3 === 1'b1)
    else begin
      failures++;
      $error("FAIL ready addr=%h got=%b%b exp=11", a, rdy1, rdy3);
    end
    if (!w || experr) begin
      e.acc  = cyc;
      e.ld   = !w;
      e.err  = experr;
      e.data = experr ? 32'h0 : exp;
      q1.push_back(e);
      q3.push_back(e);
    end
  endtask

  task automatic ld(input logic [1:0] sz, input bit u,
                    input logic [31:0] a, input logic [31:0] exp);
    acc(1'b0, sz, u, a, 32'h0, exp, 1'b0);
  endtask

  task automatic st(input logic [1:0] sz, input logic [31:0] a,
                    input logic [31:0] d);
    acc(1'b1, sz, 1'b0, a, d, 32'h0, 1'b0);
  endtask

  task automatic bad(input bit w, input logic [1:0] sz,
                     input logic [31:0] a);
    acc(w, sz, 1'b0, a, 32'hDEAD_BEEF, 32'h0, 1'b1);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk); #1;
      req = 1'b0;
    end
  endtask

  task automatic do_reset(input bit with_req);
    @(negedge clk); #1;
    reset = 1'b1; req = with_req; wr = 1'b0;
    size = 2'b10; addr = 32'h10;
    q1.delete();
    q3.delete();
    @(negedge clk); #1;
    checks++;
    assert ({rdy1, rv1, err1, rd1} === 35'h0)
    else begin
      failures++;
      $error("FAIL reset1 got rdy,rv,err=%b%b%b rd=%h exp 000/0",
             rdy1, rv1, err1, rd1);
    end
    checks++;
    assert ({rdy3, rv3, err3, rd3} === 35'h0)
    else begin
      failures++;
      $error("FAIL reset3 got rdy,rv,err=%b%b%b rd=%h exp 000/0",
             rdy3, rv3, err3, rd3);
    end
    reset = 1'b0;
    req = 1'b0;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (rdy1 !== 1'b1 && n < 200) begin
      n++;
      @(negedge clk); #1;
    end
    checks++;
    assert (n == DEPTH && rdy3 === 1'b1)
    else begin
      failures++;
      $error("FAIL init_len got=%0d rdy3=%b exp=%0d", n, rdy3, DEPTH);
    end
  endtask

  initial begin
    do_reset(1'b0);
    mon_en = 1'b1;
    wait_ready();

    for (int i = 0; i < DEPTH; i++) ld(2'b10, 1'b0, 32'(4 * i), 32'h0);

    st(2'b10, 32'h10, 32'h80FF_7F01);
    ld(2'b00, 1'b0, 32'h13, 32'hFFFF_FF80);
    ld(2'b01, 1'b1, 32'h12, 32'h0000_80FF);
    ld(2'b00, 1'b0, 32'h10, 32'h0000_0001);
    ld(2'b01, 1'b0, 32'h12, 32'hFFFF_80FF);
    ld(2'b00, 1'b1, 32'h11, 32'h0000_007F);
    ld(2'b01, 1'b0, 32'h10, 32'h0000_7F01);

    st(2'b10, 32'h20, 32'h1122_3344);
    st(2'b00, 32'h21, 32'h1234_56AA);
    ld(2'b10, 1'b0, 32'h20, 32'h1122_AA44);
    st(2'b01, 32'h22, 32'hFFFF_BEEF);
    ld(2'b11, 1'b1, 32'h20, 32'hBEEF_AA44);
    ld(2'b00, 1'b0, 32'h23, 32'hFFFF_FFBE);

    bad(1'b0, 2'b01, 32'h05);
    bad(1'b0, 2'b10, 32'(4 * DEPTH));
    bad(1'b1, 2'b10, 32'h02);
    bad(1'b1, 2'b00, 32'(4 * DEPTH));
    ld(2'b10, 1'b0, 32'h10, 32'h80FF_7F01);
    ld(2'b10, 1'b0, 32'h00, 32'h0);
    ld(2'b10, 1'b0, 32'h2C, 32'h0);
    ld(2'b00, 1'b0, 32'h2F, 32'h0);

    st(2'b00, 32'h2F, 32'h0000_005A);
    ld(2'b00, 1'b1, 32'h2F, 32'h0000_005A);
    ld(2'b10, 1'b0, 32'h2C, 32'h5A00_0000);
    ld(2'b01, 1'b0, 32'h2E, 32'h0000_5A00);

    idle(5);
    checks++;
    assert (rd1 === last1 && rd3 === last3 && rd1 === 32'h0000_5A00)
    else begin
      failures++;
      $error("FAIL hold got=%h/%h exp=%h", rd1, rd3, 32'h0000_5A00);
    end

    ld(2'b10, 1'b0, 32'h10, 32'h80FF_7F01);
    ld(2'b10, 1'b0, 32'h20, 32'hBEEF_AA44);
    do_reset(1'b1);
    wait_ready();
    ld(2'b10, 1'b0, 32'h10, 32'h0);
    ld(2'b10, 1'b0, 32'h20, 32'h0);
    ld(2'b10, 1'b0, 32'h2C, 32'h0);

    do_reset(1'b0);
    idle(4);
    do_reset(1'b0);
    wait_ready();
    ld(2'b10, 1'b0, 32'h10, 32'h0);
    idle(8);

    checks++;
    assert (q1.size() == 0 && q3.size() == 0)
    else begin
      failures++;
      $error("FAIL drain got=%0d/%0d exp=0/0", q1.size(), q3.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
